// File: rtl/serial_sub_ctrl_pkg.sv
// rtl/serial_sub_ctrl_pkg.sv - shared state encoding for the bit-serial subtractor
package serial_sub_ctrl_pkg;

   // Encoding 2'd3 is unused and is handled as IDLE by the controller.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// rtl/serial_sub_ctrl_full_sub.sv - combinational full subtractor from two half-subtractor stages
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   assign d1   = x ^ y;
   assign b1   = ~x & y;
   assign d    = d1 ^ bin;
   assign b2   = ~d1 & bin;
   assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - start/done controller running one full subtractor LSB-first over WIDTH cycles
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, a_sh_nxt;
   logic [WIDTH-1:0] b_sh, b_sh_nxt;
   logic [WIDTH-1:0] r_sh, r_sh_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             bor, bor_nxt;
   logic [WIDTH-1:0] diff_nxt;
   logic             borrow_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             d_bit;
   logic             b_bit;

   full_sub u_full_sub (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (bor),
      .d    (d_bit),
      .bout (b_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         r_sh       <= '0;
         cnt        <= '0;
         bor        <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         a_sh       <= a_sh_nxt;
         b_sh       <= b_sh_nxt;
         r_sh       <= r_sh_nxt;
         cnt        <= cnt_nxt;
         bor        <= bor_nxt;
         diff       <= diff_nxt;
         borrow_out <= borrow_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      a_sh_nxt   = a_sh;
      b_sh_nxt   = b_sh;
      r_sh_nxt   = r_sh;
      cnt_nxt    = cnt;
      bor_nxt    = bor;
      diff_nxt   = diff;
      borrow_nxt = borrow_out;
      busy_nxt   = busy;
      done_nxt   = 1'b0;

      case (state)
         RUN: begin
            a_sh_nxt = {1'b0, a_sh[WIDTH-1:1]};
            b_sh_nxt = {1'b0, b_sh[WIDTH-1:1]};
            r_sh_nxt = {d_bit, r_sh[WIDTH-1:1]};
            bor_nxt  = b_bit;
            cnt_nxt  = cnt + CW'(1);
            // Last bit: publish the assembled result directly, not the stale r_sh.
            if (cnt == LAST) begin
               state_nxt  = DONE;
               diff_nxt   = {d_bit, r_sh[WIDTH-1:1]};
               borrow_nxt = b_bit;
               done_nxt   = 1'b1;
               busy_nxt   = 1'b0;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            if (start) begin
               state_nxt = RUN;
               a_sh_nxt  = a;
               b_sh_nxt  = b;
               cnt_nxt   = '0;
               bor_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl (WIDTH=8)
module tb_serial_sub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         bor;
   } vec_t;

   typedef struct {
      logic [W-1:0] diff;
      logic         bor;
   } exp_t;

   exp_t exp_q[$];
   bit   rand_on = 1'b0;
   int   dones = 0;

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] ed, input logic eb, input string tag);
      logic [W-1:0] prev;
      int           lat;
      bit           hold_ok;
      @(negedge clk);
      prev  = diff;
      start = 1'b1;
      a     = va;
      b     = vb;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, "_busy_rise"}, busy, 1);
      lat     = 0;
      hold_ok = 1'b1;
      while (!done && lat < 40) begin
         a = W'($urandom);
         b = W'($urandom);
         @(posedge clk);
         #1 lat++;
         if (!done && diff !== prev) hold_ok = 1'b0;
      end
      check({tag, "_latency"}, lat, W);
      check({tag, "_diff_hold"}, hold_ok, 1);
      check({tag, "_diff"}, diff, ed);
      check({tag, "_borrow"}, borrow_out, eb);
      check({tag, "_busy_at_done"}, busy, 0);
      @(posedge clk);
      #1 check({tag, "_done_single"}, done, 0);
   endtask

   // Scoreboard for the random phase: every done must match the oldest accepted pair.
   always begin
      @(posedge clk);
      #1;
      if (rand_on && done) begin
         check("rand_q_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rand_result", {borrow_out, diff}, {e.bor, e.diff});
         end
         dones++;
      end
   end

   initial begin
      vec_t tbl[5];
      int   accepts;
      int   guard;
      int   last_acc;
      int   gap_bad;
      bit   prev_busy;
      bit   saw_done;

      tbl[0] = '{a: 8'h5A, b: 8'h23, diff: 8'h37, bor: 1'b0};
      tbl[1] = '{a: 8'h10, b: 8'h20, diff: 8'hF0, bor: 1'b1};
      tbl[2] = '{a: 8'h00, b: 8'h00, diff: 8'h00, bor: 1'b0};
      tbl[3] = '{a: 8'hFF, b: 8'h01, diff: 8'hFE, bor: 1'b0};
      tbl[4] = '{a: 8'h01, b: 8'hFF, diff: 8'h02, bor: 1'b1};

      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_borrow", borrow_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++)
         run_op(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].bor, $sformatf("vec%0d", i));

      // Start requests during RUN and DONE are ignored; held start is taken back in IDLE.
      @(negedge clk);
      start = 1'b1;
      a     = 8'h80;
      b     = 8'h01;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h02;
      guard = 0;
      while (!done && guard < 40) begin
         @(posedge clk);
         #1 guard++;
      end
      check("prot_first_latency", guard, W - 2);
      check("prot_first_diff", diff, 8'h7F);
      check("prot_first_borrow", borrow_out, 0);
      @(posedge clk);
      #1 check("prot_not_taken_in_done", busy, 0);
      @(posedge clk);
      #1 check("prot_taken_in_idle", busy, 1);
      start = 1'b0;
      guard = 0;
      while (!done && guard < 40) begin
         @(posedge clk);
         #1 guard++;
      end
      check("prot_second_latency", guard, W);
      check("prot_second_diff", diff, 8'hFF);
      check("prot_second_borrow", borrow_out, 1);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      start = 1'b1;
      a     = 8'h5A;
      b     = 8'h23;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_diff", diff, 0);
      check("rst_mid_borrow", borrow_out, 0);
      saw_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw_done |= done;
      end
      rst_n = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         saw_done |= done;
      end
      check("rst_no_done", saw_done, 0);
      run_op(8'h5A, 8'h23, 8'h37, 1'b0, "after_rst");

      // Random back-to-back regression with start held high.
      rand_on  = 1'b1;
      accepts  = 0;
      gap_bad  = 0;
      last_acc = 0;
      guard    = 0;
      prev_busy = busy;
      @(negedge clk);
      a     = W'($urandom);
      b     = W'($urandom);
      start = 1'b1;
      while (accepts < 1000 && guard < 20000) begin
         @(posedge clk);
         #1 guard++;
         if (busy && !prev_busy) begin
            exp_t e;
            e.diff = a - b;
            e.bor  = (a < b);
            exp_q.push_back(e);
            if (accepts > 0 && guard - last_acc != W + 2) gap_bad++;
            last_acc = guard;
            accepts++;
            if (accepts == 1000) begin
               start = 1'b0;
            end else begin
               a = W'($urandom);
               b = W'($urandom);
            end
         end
         prev_busy = busy;
      end
      guard = 0;
      while (dones < accepts && guard < 50) begin
         @(posedge clk);
         #1 guard++;
      end
      repeat (3) @(posedge clk);
      rand_on = 1'b0;
      check("rand_accepts", accepts, 1000);
      check("rand_dones", dones, accepts);
      check("rand_throughput_gaps", gap_bad, 0);
      check("rand_q_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial N-bit subtractor controller. It sequences a single full-subtractor cell (two half-subtractor stages) LSB-first over WIDTH clock cycles, holding the borrow between bits. It is a start/done-handshaked compute unit for datapaths that trade latency for area. It produces diff = a - b (mod 2^WIDTH) and a final borrow flag (set when a < b, unsigned).

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while an operation is in progress (RUN)
done  output  1  single-cycle pulse; result valid
diff  output  WIDTH  result register; holds the last completed result
borrow_out  output  1  final borrow of the last completed operation

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers, bit counter and borrow flop all 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start=1: load a_sh<=a, b_sh<=b, cnt<=0, bor<=0, and go to RUN.
  - busy is registered and rises on the same edge.
  - With start=0, stay in IDLE.
- RUN, each edge processes bit 0 of the shift registers:
  - d = a_sh[0]^b_sh[0]^bor
  - bnext = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bor)
  - r_sh <= {d, r_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; bor<=bnext; cnt<=cnt+1.
- RUN exit, on the edge where cnt==WIDTH-1:
  - Go to DONE.
  - diff <= {d, r_sh[WIDTH-1:1]} and borrow_out <= bnext.
  - done<=1, busy<=0.
- DONE: lasts exactly one cycle, then unconditionally back to IDLE with done<=0.
- Latency: start accepted at edge T0; done is high during the cycle after edge T(WIDTH). Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 or during DONE: ignored, no queuing. It must be held or re-asserted once back in IDLE.
- Operand inputs are don't-care except on the accepted start edge. Changing them mid-operation has no effect.
- diff and borrow_out change only on the completion edge. They hold their value through IDLE and through the next operation's RUN.
- Reset asserted mid-operation: immediate abort, all outputs to reset values, no done pulse.
- cnt width is $clog2(WIDTH); counting wraps are never reached because the exit is at WIDTH-1.
- Arithmetic is unsigned modular: diff equals (a - b) mod 2^WIDTH, and borrow_out = (a < b).

Decomposition:
- Shared package/include holds the state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2. 2'd3 is illegal and decodes to IDLE.
- One sub-module, full_sub:
  - Combinational: inputs x, y, bin; outputs d, bout.
  - Built from two half-subtractor stages plus an OR of their borrows.
  - Instantiated once inside serial_sub_ctrl.

Test Plan (WIDTH=8):
1. Basic subtract: a=0x5A, b=0x23, 1-cycle start pulse -> busy high for 8 cycles; done pulses 1 cycle at T0+9; diff=0x37, borrow_out=0.
2. Underflow: a=0x10, b=0x20 -> diff=0xF0, borrow_out=1. Then a=0x00, b=0x00 -> diff=0x00, borrow_out=0. a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
3. Busy/DONE protection:
   - Start a=0x80, b=0x01; assert start=1 again at T0+3 and during the DONE cycle with a=0x01, b=0x02.
   - Required: first result diff=0x7F, borrow_out=0; the second request is not taken in DONE; holding start into IDLE then yields diff=0xFF, borrow_out=1.
4. Operand stability: change a and b every cycle during RUN -> result reflects only the values captured at T0. diff must stay at the previous result until the done edge.
5. Reset mid-op: start a=0x5A, b=0x23; drop rst_n at T0+4 (asynchronous, between edges) -> busy, done, diff and borrow_out go to 0 immediately; no done pulse. After release, a fresh start completes correctly.
6. Random regression: 1000 random a/b pairs with back-to-back starts -> every done matches the (a-b) mod 256 and a<b reference model; exactly one done per accepted start.
